// File: rtl/mask_bit_iterator_pkg.sv
// Shared types and helpers for the mask bit iterator.
//   iter_state_e : iterator FSM state encoding (IDLE, ITER)
//   popcnt_le1   : true when a mask has zero or one bit set
package g2_mask_pkg;

  // Widest mask the helper accepts; narrower masks are zero-extended by a cast.
  localparam int unsigned MAX_MASK_W = 1024;
  typedef logic [MAX_MASK_W-1:0] mask_max_t;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } iter_state_e;

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  function automatic logic popcnt_le1(input mask_max_t m);
    return (m & (m - mask_max_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/mask_bit_iterator_scan.sv
// Combinational set-bit locator.
//   vec  : input bit vector
//   idx  : index of lowest set bit (MSB_FIRST=0) or highest set bit (MSB_FIRST=1);
//          0 when no bit is set
//   none : no bit set in vec
module bit_scan_index #(
  parameter int W         = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int W_IDX     = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [W_IDX-1:0] idx,
  output logic             none
);

  logic [W-1:0]     scan;
  logic [W-1:0]     win;
  logic [W_IDX-1:0] pos;

  always_comb begin
    scan = '0;
    // Reversing the input turns a highest-bit search into a lowest-bit search.
    for (int i = 0; i < W; i++) begin
      scan[i] = MSB_FIRST ? vec[W-1-i] : vec[i];
    end

    // Halving search: if the lower half of the window is empty the answer
    // lies in the upper half, so set that index bit and shift the window down.
    win = scan;
    pos = '0;
    for (int lvl = W_IDX - 1; lvl >= 0; lvl--) begin
      if ((win & ((W'(1) << (1 << lvl)) - W'(1))) == '0) begin
        pos[lvl] = 1'b1;
        win      = win >> (1 << lvl);
      end
    end

    none = (scan == '0);
    if (none) begin
      idx = '0;
    end else if (MSB_FIRST) begin
      idx = W_IDX'(W - 1) - pos;
    end else begin
      idx = pos;
    end
  end

endmodule

// File: rtl/mask_bit_iterator.sv
// Serialises a W-bit mask into the indices of its set bits, one per cycle,
// over a valid/ready stream. A zero mask produces one beat flagged empty.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : mask offer / accept handshake
//   in_mask            : mask, sampled only when accepted
//   out_valid/out_ready: index beat handshake
//   out_idx            : bit index of the current beat
//   out_last           : final beat of the current mask
//   out_empty          : current mask was all-zero
//   out_ord            : 0-based beat number within the mask
//
// state | meaning
// IDLE  | no mask held, ready to accept one
// ITER  | emitting beats for the held mask
module mask_bit_iterator
  import g2_mask_pkg::*;
#(
  parameter int W         = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int W_IDX     = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_IDX-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [W_IDX:0]   out_ord
);

  iter_state_e      state_q, state_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W_IDX:0]   ord_q, ord_d;
  logic             empty_q, empty_d;
  logic             scan_none;

  bit_scan_index #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST),
    .W_IDX     (W_IDX)
  ) u_scan (
    .vec  (rem_q),
    .idx  (out_idx),
    .none (scan_none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ord_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ord_q   <= ord_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    out_valid = (state_q == ITER);
    out_empty = empty_q;
    out_ord   = ord_q;
    // Exactly one bit left (not zero) or the zero-mask beat.
    out_last  = empty_q | (~scan_none & popcnt_le1(mask_max_t'(rem_q)));
    in_ready  = (state_q == IDLE) | (out_ready & out_last);

    state_d = state_q;
    rem_d   = rem_q;
    ord_d   = ord_q;
    empty_d = empty_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ITER;
          rem_d   = in_mask;
          ord_d   = '0;
          empty_d = (in_mask == '0);
        end
      end
      ITER: begin
        if (out_ready) begin
          if (!out_last) begin
            rem_d = rem_q & ~(W'(1) << out_idx);
            ord_d = ord_q + 1'b1;
          end else if (in_valid) begin
            rem_d   = in_mask;
            ord_d   = '0;
            empty_d = (in_mask == '0);
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            ord_d   = '0;
            empty_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mask_bit_iterator.sv
module tb_mask_bit_iterator;

  localparam int W     = 8;
  localparam int W_IDX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_mask;
  logic             out_ready;

  logic             l_in_ready, l_out_valid, l_out_last, l_out_empty;
  logic [W_IDX-1:0] l_out_idx;
  logic [W_IDX:0]   l_out_ord;
  logic             m_in_ready, m_out_valid, m_out_last, m_out_empty;
  logic [W_IDX-1:0] m_out_idx;
  logic [W_IDX:0]   m_out_ord;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mask_bit_iterator #(.W(W), .MSB_FIRST(1'b0), .W_IDX(W_IDX)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_mask(in_mask), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last), .out_empty(l_out_empty),
    .out_ord(l_out_ord)
  );

  mask_bit_iterator #(.W(W), .MSB_FIRST(1'b1), .W_IDX(W_IDX)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_mask(in_mask), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last), .out_empty(m_out_empty),
    .out_ord(m_out_ord)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] mask;
    logic       ordy;
    logic       ov;
    logic       ir;
    int         idx;
    int         midx;
    logic       last;
    logic       empty;
    int         ord;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] m, input logic ordy,
                     input logic ov, input logic ir, input int idx, input int midx,
                     input logic last, input logic empty, input int ord);
    vec_t v;
    v.rst = r; v.iv = iv; v.mask = m; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.idx = idx; v.midx = midx;
    v.last = last; v.empty = empty; v.ord = ord;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_i;
    //   rst iv mask   ordy | ov ir idx midx last empty ord
    add(1, 1, 8'hFF, 1,     0, 1, 0, 0, 0, 0, 0); // reset state, offer ignored
    add(0, 0, 8'h00, 1,     0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 8'hA6, 1,     0, 1, 0, 0, 0, 0, 0); // accept 1010_0110
    add(0, 0, 8'hFF, 1,     1, 0, 1, 7, 0, 0, 0); // in_mask change ignored
    add(0, 0, 8'h00, 1,     1, 0, 2, 5, 0, 0, 1);
    add(0, 0, 8'h00, 1,     1, 0, 5, 2, 0, 0, 2);
    add(0, 0, 8'h00, 1,     1, 1, 7, 1, 1, 0, 3);
    add(0, 1, 8'h00, 1,     0, 1, 0, 0, 0, 0, 0); // accept zero mask
    add(0, 0, 8'h00, 1,     1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 8'h01, 1,     0, 1, 0, 0, 0, 0, 0); // accept 01
    add(0, 1, 8'h80, 1,     1, 1, 0, 0, 1, 0, 0); // back-to-back accept 80
    add(0, 0, 8'h00, 1,     1, 1, 7, 7, 1, 0, 0);
    add(0, 1, 8'h06, 0,     0, 1, 0, 0, 0, 0, 0); // idle accepts without out_ready
    add(0, 0, 8'h00, 0,     1, 0, 1, 2, 0, 0, 0);
    add(0, 0, 8'h00, 0,     1, 0, 1, 2, 0, 0, 0);
    add(0, 0, 8'h00, 1,     1, 0, 1, 2, 0, 0, 0);
    add(0, 0, 8'h00, 1,     1, 1, 2, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,     0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_mask = vecs[i].mask;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d out_valid", i), int'(l_out_valid), int'(vecs[i].ov));
      chk($sformatf("v%0d in_ready", i),  int'(l_in_ready),  int'(vecs[i].ir));
      chk($sformatf("v%0d out_idx", i),   int'(l_out_idx),   vecs[i].idx);
      chk($sformatf("v%0d msb_idx", i),   int'(m_out_idx),   vecs[i].midx);
      chk($sformatf("v%0d out_last", i),  int'(l_out_last),  int'(vecs[i].last));
      chk($sformatf("v%0d out_empty", i), int'(l_out_empty), int'(vecs[i].empty));
      chk($sformatf("v%0d out_ord", i),   int'(l_out_ord),   vecs[i].ord);
      chk($sformatf("v%0d msb_valid", i), int'(m_out_valid), int'(vecs[i].ov));
      @(posedge clk);
    end

    // Backpressure: FF with out_ready 1,0,0 repeating.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_mask = 8'hFF; out_ready = 1'b1;
    @(posedge clk);
    exp_i = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = (cyc % 3 == 0);
      #1;
      if (!l_out_valid) break;
      chk("bp out_idx",  int'(l_out_idx),  exp_i);
      chk("bp msb_idx",  int'(m_out_idx),  7 - exp_i);
      chk("bp out_ord",  int'(l_out_ord),  exp_i);
      chk("bp out_last", int'(l_out_last), int'(exp_i == 7));
      if (out_ready) exp_i++;
      @(posedge clk);
    end
    chk("bp beat count", exp_i, 8);

    // Reset mid-iteration of F0.
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hF0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst beat0 idx", int'(l_out_idx), 4);
    chk("rst beat0 ord", int'(l_out_ord), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst beat1 idx", int'(l_out_idx), 5);
    chk("rst beat1 ord", int'(l_out_ord), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst beat2 idx", int'(l_out_idx), 6);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst out_valid", int'(l_out_valid), 0);
    chk("post-rst in_ready",  int'(l_in_ready),  1);
    chk("post-rst out_ord",   int'(l_out_ord),   0);
    in_valid = 1'b1; in_mask = 8'h02;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("02 out_valid", int'(l_out_valid), 1);
    chk("02 out_idx",   int'(l_out_idx),   1);
    chk("02 msb_idx",   int'(m_out_idx),   1);
    chk("02 out_ord",   int'(l_out_ord),   0);
    chk("02 out_last",  int'(l_out_last),  1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("02 done out_valid", int'(l_out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
